// File: rtl/hbm_fetch_host_pkg.sv
// hbm_fetch_host_pkg
// Shared definitions for the host-to-HBM fetch engine: FSM state type,
// beat geometry and small arithmetic helpers.
package hbm_fetch_host_pkg;

  localparam int BEAT_BYTES = 64;
  localparam int BEAT_SHIFT = 6;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_CMD   = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_DRAIN = 4'b1000
  } fetch_state_e;

  // Compact state number exposed on the debug status word.
  function automatic logic [2:0] state_code(input fetch_state_e s);
    case (s)
      ST_CMD:   return 3'd1;
      ST_WAIT:  return 3'd2;
      ST_DRAIN: return 3'd3;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/hbm_fetch_host_if.sv
// DMA-side bus interfaces of the fetch engine.
//   axis_mem_cmd : read command channel (valid/ready, 64-bit byte address,
//                  32-bit byte length). The engine is the master.
//   axi_stream   : returned read data (valid/ready, 512-bit data, keep,
//                  last). The engine is the slave.
interface axis_mem_cmd;
  logic        valid;
  logic        ready;
  logic [63:0] address;
  logic [31:0] length;

  modport master (output valid, address, length, input ready);
  modport slave  (input valid, address, length, output ready);
endinterface

interface axi_stream;
  import hbm_fetch_host_pkg::*;
  logic                      valid;
  logic                      ready;
  logic [BEAT_BYTES*8-1:0]   data;
  logic [BEAT_BYTES-1:0]     keep;
  logic                      last;

  modport master (output valid, data, keep, last, input ready);
  modport slave  (input valid, data, keep, last, output ready);
endinterface

// File: rtl/hbm_fetch_fifo.sv
// hbm_fetch_fifo
// Synchronous first-word-fall-through FIFO. The head entry is always visible
// on rdata_o while empty_o is low. Pointers and count reset asynchronously;
// the storage array is not reset.
// Ports: clk_i, rst_ni (async active-low), push_i/wdata_i, pop_i/rdata_o,
//        empty_o, full_o, count_o (occupancy).
module hbm_fetch_fifo #(
  parameter  int DATA_W = 512,
  parameter  int DEPTH  = 128,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [CNT_W-1:0]  count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/hbm_fetch_host.sv
// hbm_fetch_host
// DMA read engine: splits a contiguous host region into read commands of at
// most MAX_CMD_BYTES, buffers the returned beats in a FWFT FIFO and streams
// them out as 512-bit beats. A command is only issued when the FIFO has room
// reserved for every beat it will return, so returned data never overflows.
// Ports: hbm_clk, hbm_aresetn (async active-low), m_axis_dma_read_cmd
//        (command master), s_axis_dma_read_data (data slave), start/addr_x/
//        data_length (launch), out_data/out_valid/out_ready (output stream),
//        busy, done (one-cycle pulse), status_reg (8x32 debug counters).
module hbm_fetch_host
  import hbm_fetch_host_pkg::*;
#(
  parameter int MAX_CMD_BYTES = 4096,
  parameter int FIFO_DEPTH    = 128
) (
  input  logic                    hbm_clk,
  input  logic                    hbm_aresetn,
  axis_mem_cmd.master             m_axis_dma_read_cmd,
  axi_stream.slave                s_axis_dma_read_data,
  input  logic                    start,
  input  logic [63:0]             addr_x,
  input  logic [31:0]             data_length,
  output logic [511:0]            out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic [7:0][31:0]        status_reg
);
  localparam int MAX_BEATS = MAX_CMD_BYTES / BEAT_BYTES;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

  fetch_state_e state_q;
  logic         start_d0_q, start_d1_q, zero_done_q, done_q, ovf_q;
  logic [63:0]  addr_q;
  logic [31:0]  remaining_q, total_beats_q, reserved_q, rx_rem_q, cmd_beat_q;
  logic [31:0]  cmd_cnt_q, rx_cnt_q, pop_cnt_q, ign_cnt_q, mis_cnt_q;

  logic         launch, credit_ok, cmd_hs, push, pop, rx_end;
  logic [31:0]  chunk_len, chunk_beats, remaining_d;
  logic         fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic         unused_bits;

  assign launch      = start_d0_q & ~start_d1_q;
  assign chunk_len   = min_u32(remaining_q, 32'(MAX_CMD_BYTES));
  assign chunk_beats = chunk_len >> BEAT_SHIFT;
  assign remaining_d = remaining_q - chunk_len;
  assign credit_ok   = (reserved_q + chunk_beats) <= 32'(FIFO_DEPTH);

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign out_valid = ~fifo_empty;

  assign m_axis_dma_read_cmd.valid   = (state_q == ST_CMD) & credit_ok;
  assign m_axis_dma_read_cmd.address = addr_q;
  assign m_axis_dma_read_cmd.length  = chunk_len;
  assign cmd_hs = m_axis_dma_read_cmd.valid & m_axis_dma_read_cmd.ready;

  assign s_axis_dma_read_data.ready = ~fifo_full & busy;
  assign push = s_axis_dma_read_data.valid & s_axis_dma_read_data.ready;
  assign pop  = out_valid & out_ready;

  // Beat position within the current command: every chunk but the final
  // one is MAX_BEATS long, and the final one ends on the transfer's last beat.
  assign rx_end = (cmd_beat_q == 32'(MAX_BEATS - 1)) || (rx_rem_q == 32'd1);

  assign unused_bits = ^{s_axis_dma_read_data.keep, data_length[5:0], fifo_count};

  always_comb begin
    status_reg    = '0;
    status_reg[0] = cmd_cnt_q;
    status_reg[1] = rx_cnt_q;
    status_reg[2] = pop_cnt_q;
    status_reg[3] = ign_cnt_q;
    status_reg[4] = mis_cnt_q;
    status_reg[5] = {21'd0, state_code(state_q), 7'd0, ovf_q};
  end

  hbm_fetch_fifo #(
    .DATA_W (BEAT_BYTES * 8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (hbm_clk),
    .rst_ni  (hbm_aresetn),
    .push_i  (push),
    .wdata_i (s_axis_dma_read_data.data),
    .pop_i   (pop),
    .rdata_o (out_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
    if (!hbm_aresetn) begin
      state_q       <= ST_IDLE;
      start_d0_q    <= 1'b0;
      start_d1_q    <= 1'b0;
      zero_done_q   <= 1'b0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
      addr_q        <= '0;
      remaining_q   <= '0;
      total_beats_q <= '0;
      reserved_q    <= '0;
      rx_rem_q      <= '0;
      cmd_beat_q    <= '0;
      cmd_cnt_q     <= '0;
      rx_cnt_q      <= '0;
      pop_cnt_q     <= '0;
      ign_cnt_q     <= '0;
      mis_cnt_q     <= '0;
    end else begin
      start_d0_q  <= start;
      start_d1_q  <= start_d0_q;
      zero_done_q <= 1'b0;
      done_q      <= zero_done_q;

      reserved_q <= reserved_q + (cmd_hs ? chunk_beats : 32'd0) - {31'd0, pop};
      if (cmd_hs) cmd_cnt_q <= cmd_cnt_q + 1'b1;
      if (pop)    pop_cnt_q <= pop_cnt_q + 1'b1;
      if (push) begin
        rx_cnt_q   <= rx_cnt_q + 1'b1;
        cmd_beat_q <= rx_end ? 32'd0 : cmd_beat_q + 1'b1;
        if (rx_rem_q != 32'd0) rx_rem_q <= rx_rem_q - 1'b1;
        if (s_axis_dma_read_data.last != rx_end) mis_cnt_q <= mis_cnt_q + 1'b1;
      end
      // Data presented while the FIFO is full exceeds the reserved credit.
      if (s_axis_dma_read_data.valid & busy & fifo_full) ovf_q <= 1'b1;
      if (launch && state_q != ST_IDLE) ign_cnt_q <= ign_cnt_q + 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            addr_q        <= addr_x;
            remaining_q   <= {data_length[31:6], 6'd0};
            total_beats_q <= {6'd0, data_length[31:6]};
            rx_rem_q      <= {6'd0, data_length[31:6]};
            cmd_beat_q    <= '0;
            cmd_cnt_q     <= '0;
            rx_cnt_q      <= '0;
            pop_cnt_q     <= '0;
            if (data_length[31:6] != 26'd0) state_q     <= ST_CMD;
            else                            zero_done_q <= 1'b1;
          end
        end
        ST_CMD: begin
          if (cmd_hs) begin
            addr_q      <= addr_q + {32'd0, chunk_len};
            remaining_q <= remaining_d;
            state_q     <= (remaining_d == 32'd0) ? ST_DRAIN : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (credit_ok) state_q <= ST_CMD;
        end
        ST_DRAIN: begin
          if (pop_cnt_q == total_beats_q) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hbm_fetch_host.sv
// Testbench for hbm_fetch_host: a DMA responder answers read commands with
// random beats; a transaction-level model predicts the command list and the
// output beat order.
module tb_hbm_fetch_host;
  localparam int MAX_CMD_BYTES = 4096;
  localparam int FIFO_DEPTH    = 128;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [63:0]     addr_x;
  logic [31:0]     data_length;
  logic [511:0]    out_data;
  logic            out_valid, out_ready, busy, done;
  logic [7:0][31:0] status_reg;

  always #5 clk = ~clk;

  axis_mem_cmd cmd_if ();
  axi_stream   dat_if ();

  hbm_fetch_host #(
    .MAX_CMD_BYTES (MAX_CMD_BYTES),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .hbm_clk              (clk),
    .hbm_aresetn          (rstn),
    .m_axis_dma_read_cmd  (cmd_if),
    .s_axis_dma_read_data (dat_if),
    .start                (start),
    .addr_x               (addr_x),
    .data_length          (data_length),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .busy                 (busy),
    .done                 (done),
    .status_reg           (status_reg)
  );

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [63:0]  exp_a[$];
  logic [31:0]  exp_l[$];
  logic [511:0] exp_data[$];
  int           rsp_q[$];
  int rsp_idx = 0, cyc = 0;
  int exp_ncmd, exp_beats, n_cmd_obs, n_push, n_pop, done_cnt, busy_seen;
  int done_cyc, start_cyc, last_pop_cyc, outst, max_out;
  bit dat_busy = 0, cmd_rand = 0, rsp_rand = 0, ord_rand = 0, inj_err = 0;
  int pop_budget = -1, rsp_limit = 1 << 30;

  task automatic chk_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic [511:0] d;
    @(negedge clk);
    cyc++;
    cmd_if.ready = cmd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!dat_busy) begin
      if (rsp_q.size() != 0 && n_push < rsp_limit && (!rsp_rand || $urandom_range(0, 3) != 0)) begin
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        dat_if.data  = d;
        dat_if.last  = (rsp_idx == rsp_q[0] - 1) || (inj_err && rsp_q[0] == 4 && rsp_idx == 2);
        dat_if.valid = 1'b1;
        dat_busy     = 1'b1;
      end else begin
        dat_if.valid = 1'b0;
      end
    end
    out_ready = (pop_budget == 0) ? 1'b0 : (ord_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    #1;
    if (busy) busy_seen = 1;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (out_valid && out_ready) begin
      chk_eq("data_pending", exp_data.size() != 0, 1);
      if (exp_data.size() != 0) chk_eq("out_data", out_data, exp_data.pop_front());
      n_pop++; last_pop_cyc = cyc; outst--;
      if (pop_budget > 0) pop_budget--;
    end
    if (cmd_if.valid && cmd_if.ready) begin
      chk_eq("cmd_pending", exp_a.size() != 0, 1);
      if (exp_a.size() != 0) begin
        chk_eq("cmd_addr", cmd_if.address, exp_a.pop_front());
        chk_eq("cmd_len", cmd_if.length, exp_l.pop_front());
      end
      n_cmd_obs++;
      rsp_q.push_back(int'(cmd_if.length >> 6));
      outst += int'(cmd_if.length >> 6);
      if (outst > max_out) max_out = outst;
    end
    if (dat_if.valid && dat_if.ready) begin
      exp_data.push_back(dat_if.data);
      n_push++; dat_busy = 0; rsp_idx++;
      if (rsp_q.size() != 0 && rsp_idx == rsp_q[0]) begin
        void'(rsp_q.pop_front());
        rsp_idx = 0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic start_xfer(input logic [63:0] a, input logic [31:0] len);
    logic [31:0] rem, c;
    logic [63:0] am;
    rem = len & ~32'h3F; am = a;
    exp_beats = int'(rem >> 6); exp_ncmd = 0;
    while (rem != 0) begin
      c = (rem > MAX_CMD_BYTES) ? MAX_CMD_BYTES : rem;
      exp_a.push_back(am); exp_l.push_back(c);
      am += 64'(c); rem -= c; exp_ncmd++;
    end
    n_cmd_obs = 0; n_push = 0; n_pop = 0; done_cnt = 0; busy_seen = 0;
    done_cyc = -1; last_pop_cyc = -1; outst = 0; max_out = 0;
    addr_x = a; data_length = len;
    start = 1'b1; start_cyc = cyc;
    run(2);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget && done_cnt == 0; n++) cycle();
  endtask

  task automatic finish_xfer();
    run(4);
    chk_eq("done_cnt", done_cnt, 1);
    chk_eq("cmd_cnt", n_cmd_obs, exp_ncmd);
    chk_eq("cmd_left", exp_a.size(), 0);
    chk_eq("beats_out", n_pop, exp_beats);
    chk_eq("data_left", exp_data.size(), 0);
    chk_eq("st_cmds", status_reg[0], exp_ncmd);
    chk_eq("st_rx", status_reg[1], exp_beats);
    chk_eq("st_pop", status_reg[2], exp_beats);
    chk_eq("busy_end", busy, 0);
    chk_eq("ovf_flag", status_reg[5][0], 0);
    chk_eq("credit", max_out <= FIFO_DEPTH, 1);
  endtask

  task automatic full_xfer(input logic [63:0] a, input logic [31:0] len, input int budget);
    start_xfer(a, len);
    wait_done(budget);
    finish_xfer();
  endtask

  initial begin
    int ign0, mis0;
    rstn = 1'b0; start = 1'b0; addr_x = '0; data_length = '0; out_ready = 1'b0;
    cmd_if.ready = 1'b0; dat_if.valid = 1'b0; dat_if.data = '0;
    dat_if.keep = '1; dat_if.last = 1'b0;
    run(3);
    chk_eq("rst_cmd_valid", cmd_if.valid, 0);
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_s_ready", dat_if.ready, 0);
    rstn = 1'b1;
    run(2);
    for (int k = 0; k < 8; k++) chk_eq($sformatf("rst_status%0d", k), status_reg[k], 0);

    // single chunk, done one cycle after last pop
    full_xfer(64'h1000, 256, 200);
    chk_eq("single_done_lat", done_cyc - last_pop_cyc, 2);

    // split into three commands
    full_xfer(64'h0002_0000, 10240, 1000);

    // zero-length transfers
    for (int z = 0; z < 2; z++) begin
      start_xfer(64'h5000, (z == 0) ? 32'd0 : 32'd63);
      wait_done(20);
      chk_eq("zl_done_lat", done_cyc - start_cyc, 3);
      finish_xfer();
      chk_eq("zl_busy", busy_seen, 0);
    end

    // credit stall with downstream blocked
    pop_budget = 0;
    start_xfer(64'h4000, 16384);
    run(400);
    chk_eq("stall_cmds", n_cmd_obs, 2);
    chk_eq("stall_state", status_reg[5][10:8], 2);
    chk_eq("stall_fill", n_push, 128);
    pop_budget = 63;
    for (int n = 0; n < 300 && pop_budget != 0; n++) cycle();
    run(10);
    chk_eq("stall_63_pops", n_cmd_obs, 2);
    pop_budget = 1;
    for (int n = 0; n < 50 && pop_budget != 0; n++) cycle();
    run(10);
    chk_eq("stall_64_pops", n_cmd_obs, 3);
    pop_budget = -1;
    wait_done(2000);
    finish_xfer();

    // early last inside a 4-beat chunk
    mis0 = int'(status_reg[4]);
    inj_err = 1;
    full_xfer(64'h3000, 256, 200);
    inj_err = 0;
    chk_eq("last_mismatch", int'(status_reg[4]) - mis0, 1);

    // start while busy is ignored
    ord_rand = 1;
    ign0 = int'(status_reg[3]);
    start_xfer(64'h9000, 8192);
    run(10);
    start = 1'b1; run(2); start = 1'b0;
    wait_done(2000);
    finish_xfer();
    chk_eq("ignored_start", int'(status_reg[3]) - ign0, 1);
    ord_rand = 0;

    // reset during DRAIN with 10 beats buffered
    pop_budget = 0; rsp_limit = 10;
    start_xfer(64'h8000, 4096);
    for (int n = 0; n < 200 && n_push < 10; n++) cycle();
    run(3);
    chk_eq("pre_rst_state", status_reg[5][10:8], 3);
    chk_eq("pre_rst_ovalid", out_valid, 1);
    chk_eq("pre_rst_rx", status_reg[1], 10);
    #2 rstn = 1'b0;
    #1;
    chk_eq("arst_out_valid", out_valid, 0);
    chk_eq("arst_cmd_valid", cmd_if.valid, 0);
    chk_eq("arst_busy", busy, 0);
    chk_eq("arst_s_ready", dat_if.ready, 0);
    chk_eq("arst_mismatch", status_reg[4], 0);
    chk_eq("arst_ignored", status_reg[3], 0);
    exp_a.delete(); exp_l.delete(); exp_data.delete(); rsp_q.delete();
    rsp_idx = 0; dat_busy = 0; dat_if.valid = 1'b0;
    pop_budget = -1; rsp_limit = 1 << 30;
    run(2);
    rstn = 1'b1;
    run(2);
    full_xfer(64'h0002_0000, 128, 200);

    // randomized transfers, including 64-bit address wrap
    cmd_rand = 1; rsp_rand = 1; ord_rand = 1;
    for (int i = 0; i < 6; i++) begin
      logic [63:0] a;
      logic [31:0] len;
      a = {$urandom, $urandom} & ~64'h3F;
      if (i == 0) a = 64'hFFFF_FFFF_FFFF_F000;
      len = (i == 0) ? 32'd10000 : 32'($urandom_range(0, 20000));
      full_xfer(a, len, 6000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hbm_fetch_host.md
Name: hbm_fetch_host

Overview:
- DMA read engine that pulls a contiguous host-memory region into the HBM clock domain.
- Counterpart of the HBM-to-host write-back path. It issues read commands on the DMA command interface and accepts the returned read data stream.
- Returned data is buffered in a credit-protected FIFO and presented as a 512-bit valid/ready stream toward the HBM write logic.
- Large transfers are split into bounded command chunks. A chunk is issued only when the FIFO is guaranteed to have room for all of its data.

Parameters:
- MAX_CMD_BYTES, 4096, maximum byte length of one DMA read command; power of two, multiple of 64.
- FIFO_DEPTH, 128, 512-bit entries in the receive FIFO; must be at least MAX_CMD_BYTES/64.

Ports:
- hbm_clk  in  1  clock.
- hbm_aresetn  in  1  asynchronous active-low reset.
- m_axis_dma_read_cmd  axis_mem_cmd.master  -  valid/ready, address[63:0], length[31:0] (bytes).
- s_axis_dma_read_data  axi_stream.slave  -  valid/ready, data[511:0], keep[63:0], last.
- start  in  1  rising edge launches a transfer.
- addr_x  in  64  host byte address; 64-byte aligned.
- data_length  in  32  total bytes; bits [5:0] ignored (truncated to whole beats).
- out_data  out  512  fetched beat.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the last beat is accepted downstream.
- status_reg  out  8x32  debug counters.

Behaviour:
- Reset (async assert, synchronous release): FSM=IDLE, all counters 0, FIFO empty, cmd valid=0, out_valid=0, busy=0, done=0, s_axis ready=0.
- start is registered twice. The launch event is start_d0 & ~start_d1 (2-cycle latency from the start pin).
  - In IDLE, a launch latches addr_x and data_length into addr_r and remaining_r; total_beats = data_length[31:6].
  - A launch outside IDLE is ignored and increments status_reg[3].
- Chunk length = min(remaining_r, MAX_CMD_BYTES); chunk_beats = chunk length / 64.
- Credit: reserved = beats of issued commands not yet popped from the FIFO. A command may be asserted only when reserved + chunk_beats <= FIFO_DEPTH.
- FSM states (one-hot):
  - IDLE: on launch, go to CMD if total_beats != 0. Otherwise pulse done the next cycle and stay in IDLE.
  - CMD: cmd valid=1 with address=addr_r and length=chunk length. Address and length are held stable while valid and ready=0.
    - On handshake: addr_r += chunk length, remaining_r -= chunk length, reserved += chunk_beats.
    - If remaining_r becomes 0, go to DRAIN; else go to WAIT.
  - WAIT: go to CMD when the credit condition holds, evaluated on the post-update reserved value. A single cycle in WAIT is allowed.
  - DRAIN: no further commands. When popped_beats == total_beats, pulse done, go to IDLE, busy=0.
- busy=1 in CMD/WAIT/DRAIN.
- s_axis ready = ~fifo_full & busy. Each accepted beat pushes data into the FIFO; keep is not stored and the output is full-beat.
- Beat count check: count beats received per command. Any mismatch increments status_reg[4] and does not stall. Mismatch means one of:
  - last asserted on a beat other than beat chunk_beats-1, or
  - last missing on beat chunk_beats-1.
- FIFO is first-word-fall-through: out_valid = ~fifo_empty, out_data = FIFO head. Pop on out_valid & out_ready.
- When a push and a pop happen in the same cycle, the occupancy count is unchanged and reserved decrements by 1.
- Data arriving while not busy is dropped with ready=0; only reset recovers.
- Data in flight is never lost: the credit rule makes FIFO overflow impossible. An overflow attempt asserts an internal error flag and sets status_reg[5][0].
- Reset mid-transfer discards FIFO contents and outstanding credit immediately.
- Arithmetic: address is 64-bit wrapping; all counters are 32-bit.
- status_reg contents:
  - [0] commands issued.
  - [1] beats received.
  - [2] beats popped.
  - [3] ignored starts.
  - [4] last mismatches.
  - [5] bit0 overflow, bits[2:0]... FSM state in bits[10:8].
  - [6]/[7] zero.
  - [0]/[1]/[2] clear on launch; [3]/[4]/[5] clear only on reset.

Decomposition:
- Shared package: FSM state typedef (IDLE, CMD, WAIT, DRAIN), BEAT_BYTES=64, BEAT_SHIFT=6.
- One sub-module: hbm_fetch_fifo, a synchronous FWFT FIFO with parameterised depth and width.
  - Outputs: empty, full, count.
  - Async active-low reset on pointers.

Test Plan:
- Single chunk: addr=0x1000, len=256, MAX=4096, out_ready=1 → one cmd (0x1000, 256); 4 beats out in order; done 1 cycle after the 4th pop; status[0]=1, [1]=4.
- Split: len=10240, MAX=4096 → cmds (A, 4096), (A+4096, 4096), (A+8192, 2048); 160 beats out; done once.
- Credit stall: FIFO_DEPTH=128, MAX=4096, len=16384, out_ready=0 → exactly 2 cmds issued, then WAIT. After 64 pops, a 3rd cmd issues; no overflow flag.
- Zero length: len=0 or len=63 → no cmd; done pulse 3 cycles after start rises; busy stays 0.
- Protocol errors: last on beat 2 of a 4-beat chunk → status[4]=1 and the transfer still completes. A start during busy → status[3]=1 with no effect.
- Reset mid-transfer: assert hbm_aresetn low during DRAIN with 10 beats buffered → out_valid=0 and cmd valid=0 asynchronously; after release, a new transfer of len=128 works normally.
